// File: rtl/dm_obi_sba_master.sv
// dm_obi_sba_master: OBI master adapter for the Debug Module SBA port.
// Accepts single-beat SBA requests, registers the address phase until OBI grant,
// numbers transactions with a wrapping aid, limits outstanding transactions and
// passes in-order responses straight back upstream.
// Optional macro DM_OBI_SBA_RID_CHECK_EN: compare each accepted response ID with
// the expected ID and flag mismatches on rid_err_o.
module dm_obi_sba_master #(
    parameter int IdWidth        = 1,
    parameter int BusWidth       = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sba_req_i,
    input  logic [BusWidth-1:0]   sba_add_i,
    input  logic                  sba_we_i,
    input  logic [BusWidth-1:0]   sba_wdata_i,
    input  logic [BusWidth/8-1:0] sba_be_i,
    output logic                  sba_gnt_o,
    output logic                  sba_r_valid_o,
    output logic [BusWidth-1:0]   sba_r_rdata_o,
    output logic                  sba_r_err_o,
    output logic                  obi_req_o,
    input  logic                  obi_gnt_i,
    output logic [BusWidth-1:0]   obi_addr_o,
    output logic                  obi_we_o,
    output logic [BusWidth/8-1:0] obi_be_o,
    output logic [BusWidth-1:0]   obi_wdata_o,
    output logic [IdWidth-1:0]    obi_aid_o,
    input  logic                  obi_rvalid_i,
    input  logic [BusWidth-1:0]   obi_rdata_i,
    input  logic [IdWidth-1:0]    obi_rid_i,
    input  logic                  obi_err_i,
    output logic                  rid_err_o
);

    localparam int CW = $clog2(MaxOutstanding + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MaxOutstanding);

    if (MaxOutstanding < 1 || MaxOutstanding > (1 << IdWidth)) begin : g_bad_cfg
        $error("dm_obi_sba_master: MaxOutstanding must be within 1..2**IdWidth");
    end

    typedef enum logic {IDLE, ADDR} state_t;

    state_t              state;
    logic [CW-1:0]       cnt_q;
    logic [IdWidth-1:0]  aid_q;
    logic                rid_err_q;
    logic                hs;
    logic                rsp_acc;
    logic                rsp_bad;
    logic                rid_mis;

    assign sba_gnt_o     = (state == IDLE) && (cnt_q < MAX_CNT);
    assign obi_req_o     = (state == ADDR);
    assign obi_aid_o     = aid_q;
    assign hs            = obi_req_o && obi_gnt_i;
    assign rsp_acc       = obi_rvalid_i && (cnt_q != '0);
    assign rsp_bad       = obi_rvalid_i && (cnt_q == '0);
    assign sba_r_valid_o = rsp_acc;
    assign sba_r_rdata_o = obi_rdata_i;
    assign sba_r_err_o   = obi_err_i;
    assign rid_err_o     = rid_err_q;

`ifdef DM_OBI_SBA_RID_CHECK_EN
    logic [IdWidth-1:0] exp_q;
    assign rid_mis = rsp_acc && (obi_rid_i != exp_q);

    // Expected response ID advances with every accepted response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) exp_q <= '0;
        else if (rsp_acc) exp_q <= exp_q + IdWidth'(1);
    end
`else
    logic unused_rid;
    assign unused_rid = ^obi_rid_i;
    assign rid_mis    = 1'b0;
`endif

    // Address FSM: capture the upstream request, hold it on OBI until granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            obi_addr_o  <= '0;
            obi_we_o    <= 1'b0;
            obi_be_o    <= '0;
            obi_wdata_o <= '0;
            aid_q       <= '0;
        end else if (state == IDLE) begin
            if (sba_req_i && sba_gnt_o) begin
                state       <= ADDR;
                obi_addr_o  <= sba_add_i;
                obi_we_o    <= sba_we_i;
                obi_be_o    <= sba_be_i;
                obi_wdata_o <= sba_wdata_i;
            end
        end else if (obi_gnt_i) begin
            state <= IDLE;
            aid_q <= aid_q + IdWidth'(1);
        end
    end

    // Outstanding count: up on OBI handshake, down on accepted response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else if (hs && !rsp_acc) cnt_q <= cnt_q + CW'(1);
        else if (!hs && rsp_acc) cnt_q <= cnt_q - CW'(1);
    end

    // Sticky error for unexpected responses and ID mismatches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rid_err_q <= 1'b0;
        else if (rsp_bad || rid_mis) rid_err_q <= 1'b1;
    end

endmodule
